// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the single-step / free-run controller.
//   ST_*            : FSM state encodings, also driven out on state_out
//   RUN_DIV_DEFAULT : default clocks per instruction in run mode
package step_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_STEP  = 2'b01;
    localparam state_t ST_RUN   = 2'b10;
    localparam state_t ST_BREAK = 2'b11;

    localparam int unsigned RUN_DIV_DEFAULT = 50_000_000;

endpackage

// File: rtl/step_controller_if.sv
// Bundle between the step controller and the datapath / front panel.
//   step_btn, run_sw, stall_in, bp_en, bp_addr, pc_in : requests and status into the controller
//   step_en, state_out, step_count, at_bp             : commit strobe and status out of it
// master = controller side, slave = datapath / panel side.
interface step_controller_if;

    logic        step_btn;
    logic        run_sw;
    logic        stall_in;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc_in;
    logic        step_en;
    logic [1:0]  state_out;
    logic [31:0] step_count;
    logic        at_bp;

    modport master (
        input  step_btn,
        input  run_sw,
        input  stall_in,
        input  bp_en,
        input  bp_addr,
        input  pc_in,
        output step_en,
        output state_out,
        output step_count,
        output at_bp
    );

    modport slave (
        output step_btn,
        output run_sw,
        output stall_in,
        output bp_en,
        output bp_addr,
        output pc_in,
        input  step_en,
        input  state_out,
        input  step_count,
        input  at_bp
    );

endinterface

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level and emits a one-cycle pulse on its rising edge.
//   i_clock : system clock
//   i_reset : asynchronous active-high reset
//   i_async : raw asynchronous level
//   o_rise  : one-cycle pulse, synchronous to i_clock
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    // Fills with ones after reset; marks when r_sync holds real samples rather than reset zeros.
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= '0;
            r_fill <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_async);
            r_fill <= (r_fill << 1) | SYNC_STAGES'(1'b1);
            // Until the chain is refilled, pretend the previous sample was high so a level
            // held through reset release is not mistaken for a fresh press.
            r_prev <= r_fill[SYNC_STAGES-1] ? w_sync_out : 1'b1;
        end
    end

    assign o_rise = w_sync_out & ~r_prev;

endmodule

// File: rtl/step_controller.sv
// Single-step / free-run controller for a teaching datapath.
//   clock, reset : system clock, asynchronous active-high reset
//   bus.step_btn : raw single-step button          bus.run_sw   : free-run enable
//   bus.stall_in : datapath not ready              bus.bp_en/bp_addr/pc_in : breakpoint compare
//   bus.step_en  : one-cycle commit strobe         bus.state_out: IDLE/STEP/RUN/BREAK
//   bus.step_count : number of commits since reset bus.at_bp    : high in BREAK
module step_controller
    import step_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DIV     = RUN_DIV_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    step_controller_if.master bus
);

    localparam int unsigned      DIV_W    = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(RUN_DIV - 1);

    state_t           r_state;
    state_t           w_state_d;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_d;
    logic [31:0]      r_count;
    logic             w_step_req;
    logic             w_bp_hit;
    logic             w_term;
    logic             w_step_en;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .i_clock (clock),
        .i_reset (reset),
        .i_async (bus.step_btn),
        .o_rise  (w_step_req)
    );

    assign w_term   = (r_div == DIV_TERM);
    assign w_bp_hit = bus.bp_en && (bus.pc_in == bus.bp_addr);

    always_comb begin
        w_state_d = r_state;
        w_div_d   = r_div;
        w_step_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_div_d = '0;
                // run_sw wins; a coincident step request is dropped
                if (bus.run_sw) begin
                    w_state_d = ST_RUN;
                end else if (w_step_req) begin
                    w_state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                w_div_d   = '0;
                w_step_en = !bus.stall_in;
                if (!bus.stall_in) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!bus.run_sw) begin
                    w_state_d = ST_IDLE;
                    w_div_d   = '0;
                end else if (!w_term) begin
                    w_div_d = r_div + DIV_W'(1);
                end else if (bus.stall_in) begin
                    w_div_d = r_div;
                end else if (w_bp_hit) begin
                    w_state_d = ST_BREAK;
                    w_div_d   = '0;
                end else begin
                    w_step_en = 1'b1;
                    w_div_d   = '0;
                end
            end
            ST_BREAK: begin
                w_div_d = '0;
                // Only a step request leaves BREAK; it executes the breakpoint instruction.
                if (w_step_req) begin
                    w_state_d = ST_STEP;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_div_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_div   <= w_div_d;
            if (w_step_en) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign bus.step_en    = w_step_en;
    assign bus.state_out  = r_state;
    assign bus.step_count = r_count;
    assign bus.at_bp      = (r_state == ST_BREAK);

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter RUN_DIV, default 50_000_000, clocks per instruction in run mode (legal range 2 to 2^26).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for step_btn.
REQ-003 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port step_btn  input  1  raw, asynchronous single-step request (level).
REQ-006 SHALL have port run_sw  input  1  free-run enable (level, quasi-static).
REQ-007 SHALL have port stall_in  input  1  datapath/serial not ready; blocks step_en while high.
REQ-008 SHALL have port bp_en  input  1  breakpoint enable.
REQ-009 SHALL have port bp_addr  input  32  breakpoint PC.
REQ-010 SHALL have port pc_in  input  32  current datapath PC.
REQ-011 SHALL have port step_en  output  1  one-cycle commit strobe to the datapath (PC, register file and memory enables).
REQ-012 SHALL have port state_out  output  2  FSM state: IDLE=00, STEP=01, RUN=10, BREAK=11.
REQ-013 SHALL have port step_count  output  32  count of step_en pulses since reset.
REQ-014 SHALL have port at_bp  output  1  high while state is BREAK.

Function
REQ-015 SHALL pass step_btn through SYNC_STAGES flops, then rising-edge detect it into a one-cycle step_req.
REQ-016 step_btn sampled high at edge k (SYNC_STAGES=2) SHALL produce a step_en pulse in the cycle after edge k+2.
REQ-017 IDLE: run_sw=1 -> RUN; else step_req -> STEP; when both occur in the same cycle, run_sw SHALL take priority and step_req SHALL be discarded.
REQ-018 STEP: step_en SHALL equal !stall_in; stay in STEP while stall_in=1; -> IDLE after the cycle in which step_en=1; exactly one pulse per entry.
REQ-019 STEP SHALL ignore the breakpoint.
REQ-020 RUN: a divider counts 0..RUN_DIV-1 and wraps; terminal count SHALL be RUN_DIV-1.
REQ-021 RUN, at terminal count with stall_in=1: divider SHALL hold at terminal, with step_en=0, until stall_in=0.
REQ-022 RUN, at terminal count with stall_in=0: bp_hit=(bp_en && pc_in==bp_addr); bp_hit=1 -> BREAK with step_en=0; else step_en=1 and divider -> 0.
REQ-023 RUN, run_sw=0 -> IDLE, divider cleared, no pulse that cycle; step_req in RUN SHALL be ignored.
REQ-024 BREAK: step_req -> STEP (executes the breakpoint instruction); run_sw alone SHALL NOT leave BREAK. After that STEP, FSM goes to IDLE and re-enters RUN next cycle if run_sw=1.
REQ-025 step_en SHALL be combinational from state, divider, stall_in and bp_hit only; never high in IDLE or BREAK.
REQ-026 step_count SHALL increment by 1 on each clock edge where step_en=1, wrapping 0xFFFF_FFFF -> 0.
REQ-027 Divider width SHALL be $clog2(RUN_DIV); no other counters besides step_count.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force: state IDLE, step_en=0, divider=0, step_count=0, synchronizer and edge flops=0, at_bp=0.
REQ-029 reset mid-STEP or mid-RUN SHALL abort without a pulse; a step_btn held high through reset release SHALL NOT generate a step.

Structure
REQ-030 State encodings and the RUN_DIV default SHALL live in shared package step_ctrl_pkg.
REQ-031 Synchronizer and edge detect SHALL be sub-module edge_sync (parameter SYNC_STAGES, output one-cycle rise pulse).
REQ-032 The FSM, divider, breakpoint compare and step_count SHALL reside in step_controller.

Verification (bench RUN_DIV=4; PC model: pc starts 0x0040_0000, +4 per step_en)
REQ-033 reset, then step_btn high 5 cycles -> exactly one step_en, in the cycle after the 3rd edge; step_count=1; state_out returns to 00.
REQ-034 run_sw=1 for 20 cycles, stall_in=0, bp_en=0 -> step_en every 4th cycle, 5 pulses, step_count=5, pc=0x0040_0014.
REQ-035 bp_en=1, bp_addr=0x0040_0008, run_sw=1 -> 2 pulses, then state_out=11 and at_bp=1 with no further pulses; a step_btn edge then gives 1 pulse, pc=0x0040_000C, and RUN resumes.
REQ-036 stall_in high for 3 cycles, starting at the RUN terminal count -> pulse delayed exactly 3 cycles, single pulse, divider restarts at 0.
REQ-037 run_sw=1 and step_btn edge arriving in the same IDLE cycle -> RUN entered; no extra STEP pulse.
REQ-038 reset asserted between edges mid-RUN -> step_en low within the same cycle, state_out=00, step_count=0.
